// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, control-vector bit positions, ID state encoding.
// No logic; imported by the decode stage, its controller and its interface.
package decode_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h5;
   localparam logic [3:0] OP_SW   = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_J    = 4'h9;
   localparam logic [3:0] OP_STOP = 4'hF;

   // Control vector, MSB first: {Floating, Mov, MemToReg, MemWrite, RegDst, MemRead, Branch, ALUop, RegWrite}
   localparam int CV_WIDTH      = 9;
   localparam int CV_REG_WRITE  = 0;
   localparam int CV_ALU_OP     = 1;
   localparam int CV_BRANCH     = 2;
   localparam int CV_MEM_READ   = 3;
   localparam int CV_REG_DST    = 4;
   localparam int CV_MEM_WRITE  = 5;
   localparam int CV_MEM_TO_REG = 6;
   localparam int CV_MOV        = 7;
   localparam int CV_FLOATING   = 8;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

endpackage

// File: rtl/decode_if.sv
// Fetch->decode and decode->execute valid/ready channels of the ID stage.
// master = surrounding pipeline (fetch + execute), slave = decode stage.
interface decode_if
   import decode_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int REG_WIDTH  = 4,
   parameter int IMM_WIDTH  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_pc;
   logic [DATA_WIDTH-1:0] in_instr;

   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] out_pc;
   logic [REG_WIDTH-1:0]  out_rs;
   logic [REG_WIDTH-1:0]  out_rt;
   logic [REG_WIDTH-1:0]  out_rd;
   logic [IMM_WIDTH-1:0]  out_imm;
   logic [CV_WIDTH-1:0]   out_ctrl;

   modport master (
      output in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_imm, out_ctrl
   );

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_imm, out_ctrl
   );
endinterface

// File: rtl/decode_ctrl.sv
// Opcode -> control vector / jump / stop / r_type; purely combinational, zero latency.
// No handshake; unknown opcodes decode as NOP.
module decode_ctrl
   import decode_pkg::*;
#(
   parameter int OP_WIDTH = 4
) (
   input  logic [OP_WIDTH-1:0] op,
   output logic [CV_WIDTH-1:0] ctrl,
   output logic                jump,
   output logic                stop,
   output logic                r_type
);

   always_comb begin
      ctrl   = '0;
      jump   = 1'b0;
      stop   = 1'b0;
      r_type = 1'b0;
      case (op)
         OP_WIDTH'(OP_ADD): begin
            ctrl[CV_REG_WRITE] = 1'b1;
            ctrl[CV_REG_DST]   = 1'b1;
            ctrl[CV_ALU_OP]    = 1'b1;
            r_type             = 1'b1;
         end
         OP_WIDTH'(OP_LW): begin
            ctrl[CV_REG_WRITE]  = 1'b1;
            ctrl[CV_MEM_READ]   = 1'b1;
            ctrl[CV_MEM_TO_REG] = 1'b1;
         end
         OP_WIDTH'(OP_SW):   ctrl[CV_MEM_WRITE] = 1'b1;
         OP_WIDTH'(OP_BEQ): begin
            ctrl[CV_BRANCH] = 1'b1;
            ctrl[CV_ALU_OP] = 1'b1;
         end
         OP_WIDTH'(OP_J):    jump = 1'b1;
         OP_WIDTH'(OP_STOP): stop = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_pipe.sv
// Instruction decode with 2-entry elastic ID/EX buffer; accept->out_valid one edge, jump/hazard taps combinational.
// in_ready drops when the buffer is full or in HALT, independent of out_ready.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int REG_WIDTH  = 4,
   parameter int OP_WIDTH   = 4,
   parameter int IMM_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   decode_if.slave              bus,
   input  logic                 flush,
   input  logic                 resume,
   output logic                 jump,
   output logic [IMM_WIDTH-1:0] jump_addr,
   output logic [REG_WIDTH-1:0] rs_d,
   output logic [REG_WIDTH-1:0] rt_d,
   output logic                 reg_write_d,
   output logic                 r_type_d,
   output logic                 halted
);

   localparam int RS_MSB = DATA_WIDTH - OP_WIDTH - 1;
   localparam int RT_MSB = RS_MSB - REG_WIDTH;
   localparam int RD_MSB = RT_MSB - REG_WIDTH;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [REG_WIDTH-1:0]  rs;
      logic [REG_WIDTH-1:0]  rt;
      logic [REG_WIDTH-1:0]  rd;
      logic [IMM_WIDTH-1:0]  imm;
      logic [CV_WIDTH-1:0]   ctrl;
   } entry_t;

   entry_t        mem [2];
   entry_t        head;
   entry_t        new_entry;
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   state_t        state;

   logic [OP_WIDTH-1:0] op;
   logic [CV_WIDTH-1:0] dec_ctrl;
   logic                dec_jump;
   logic                dec_stop;
   logic                dec_r_type;
   logic                accept;
   logic                push;
   logic                pop;

   assign op = bus.in_instr[DATA_WIDTH-1 -: OP_WIDTH];

   decode_ctrl #(.OP_WIDTH(OP_WIDTH)) u_ctrl (
      .op     (op),
      .ctrl   (dec_ctrl),
      .jump   (dec_jump),
      .stop   (dec_stop),
      .r_type (dec_r_type)
   );

   assign bus.in_ready = rst_n & (state == RUN) & (count != 2'd2);
   assign accept       = bus.in_valid & bus.in_ready;
   // Jumps resolve here and never occupy a slot; a flush drops the accepted word.
   assign push         = accept & ~dec_jump & ~flush;
   assign pop          = bus.out_valid & bus.out_ready;

   assign jump        = accept & dec_jump;
   assign jump_addr   = bus.in_instr[IMM_WIDTH-1:0];
   assign rs_d        = bus.in_instr[RS_MSB -: REG_WIDTH];
   assign rt_d        = bus.in_instr[RT_MSB -: REG_WIDTH];
   assign reg_write_d = bus.in_valid & dec_ctrl[CV_REG_WRITE];
   assign r_type_d    = bus.in_valid & dec_r_type;

   assign new_entry.pc   = bus.in_pc;
   assign new_entry.rs   = bus.in_instr[RS_MSB -: REG_WIDTH];
   assign new_entry.rt   = bus.in_instr[RT_MSB -: REG_WIDTH];
   assign new_entry.rd   = bus.in_instr[RD_MSB -: REG_WIDTH];
   assign new_entry.imm  = bus.in_instr[IMM_WIDTH-1:0];
   assign new_entry.ctrl = dec_ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         state  <= RUN;
      end else begin
         if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= new_entry;
               wr_ptr      <= ~wr_ptr;
            end
            if (pop)
               rd_ptr <= ~rd_ptr;
            case ({push, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: ;
            endcase
         end
         case (state)
            RUN:     if (accept && dec_stop && !flush) state <= HALT;
            HALT:    if (resume) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   assign head          = mem[rd_ptr];
   assign bus.out_valid = (count != 2'd0);
   assign bus.out_pc    = head.pc;
   assign bus.out_rs    = head.rs;
   assign bus.out_rt    = head.rt;
   assign bus.out_rd    = head.rd;
   assign bus.out_imm   = head.imm;
   assign bus.out_ctrl  = head.ctrl;
   assign halted        = (state == HALT) && (count == 2'd0);

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: driver models accept/flush/HALT and queues expected micro-ops,
// an independent monitor pops and compares whenever the DUT hands a micro-op to execute.
module tb_decode_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       resume = 1'b0;
   logic       jump, reg_write_d, r_type_d, halted;
   logic [7:0] jump_addr;
   logic [3:0] rs_d, rt_d;

   decode_if bus ();

   decode_pipe dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .flush       (flush),
      .resume      (resume),
      .jump        (jump),
      .jump_addr   (jump_addr),
      .rs_d        (rs_d),
      .rt_d        (rt_d),
      .reg_write_d (reg_write_d),
      .r_type_d    (r_type_d),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pc;
      logic [3:0] rs, rt, rd;
      logic [7:0] imm;
      logic [8:0] ctrl;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   bit   m_halt = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Architectural control vector of each opcode, bit order {Fl,Mov,M2R,MW,RDst,MR,Br,ALU,RW}
   function automatic logic [8:0] ref_ctrl(input logic [3:0] op);
      case (op)
         4'h1:    return 9'b0_0001_0011;
         4'h5:    return 9'b0_0100_1001;
         4'h6:    return 9'b0_0010_0000;
         4'h8:    return 9'b0_0000_0110;
         default: return 9'b0;
      endcase
   endfunction

   // One clock cycle: drive at negedge, check combinational taps, then update the model.
   task automatic cyc(input logic v, input logic [7:0] pc, input logic [15:0] ins,
                      input logic fl, input logic res, input logic ordy);
      logic [3:0] op;
      logic       m_rdy, acc;
      exp_t       e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_pc     = pc;
      bus.in_instr  = ins;
      flush         = fl;
      resume        = res;
      bus.out_ready = ordy;
      #1;
      op    = ins[15:12];
      m_rdy = rst_n && !m_halt && (exp_q.size() < 2);
      acc   = v && m_rdy;
      chk("in_ready",    bus.in_ready, m_rdy);
      chk("jump",        jump, acc && op == 4'h9);
      chk("jump_addr",   jump_addr, ins[7:0]);
      chk("rs_d",        rs_d, ins[11:8]);
      chk("rt_d",        rt_d, ins[7:4]);
      chk("reg_write_d", reg_write_d, v && (op == 4'h1 || op == 4'h5));
      chk("r_type_d",    r_type_d, v && op == 4'h1);
      chk("halted",      halted, m_halt && exp_q.size() == 0);
      #2;
      if (fl) begin
         exp_q.delete();
      end else if (acc && op != 4'h9) begin
         e.pc = pc; e.rs = ins[11:8]; e.rt = ins[7:4]; e.rd = ins[3:0];
         e.imm = ins[7:0]; e.ctrl = ref_ctrl(op);
         exp_q.push_back(e);
      end
      if (m_halt && res)
         m_halt = 1'b0;
      else if (acc && op == 4'hF && !fl)
         m_halt = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         chk("out_valid", bus.out_valid, exp_q.size() != 0);
         if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("out_pc",   bus.out_pc,   mon_e.pc);
            chk("out_rs",   bus.out_rs,   mon_e.rs);
            chk("out_rt",   bus.out_rt,   mon_e.rt);
            chk("out_rd",   bus.out_rd,   mon_e.rd);
            chk("out_imm",  bus.out_imm,  mon_e.imm);
            chk("out_ctrl", bus.out_ctrl, mon_e.ctrl);
         end
      end
   end

   logic [3:0]  ops [8];
   logic [15:0] rnd_ins;
   int          ix;

   initial begin
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
      ops = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h8, 4'h9, 4'hF, 4'h3};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_pc",    bus.out_pc, 8'h0);
      chk("rst_out_ctrl",  bus.out_ctrl, 9'h0);
      chk("rst_halted",    halted, 1'b0);
      chk("rst_in_ready",  bus.in_ready, 1'b0);
      rst_n = 1'b1;

      // ADD r3=r1+r2 streamed, then drained
      cyc(1, 8'h10, 16'h1123, 0, 0, 1);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);
      // LW, SW absorbed with execute stalled, third word refused, then in-order drain
      cyc(1, 8'h20, 16'h5450, 0, 0, 0);
      cyc(1, 8'h21, 16'h6450, 0, 0, 0);
      cyc(1, 8'h22, 16'h1123, 0, 0, 0);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);
      // Jump resolves in ID
      cyc(1, 8'h30, 16'h9042, 0, 0, 1);
      // STOP, refused word while halted, drain, halted, resume
      cyc(1, 8'h31, 16'hF000, 0, 0, 0);
      cyc(1, 8'h32, 16'h1123, 0, 0, 0);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);
      cyc(0, 8'h00, 16'h0000, 0, 0, 0);
      cyc(0, 8'h00, 16'h0000, 0, 1, 0);
      cyc(1, 8'h33, 16'h8123, 0, 0, 1);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);
      // Full buffer flushed together with an incoming ADD
      cyc(1, 8'h34, 16'h1456, 0, 0, 0);
      cyc(1, 8'h35, 16'h5789, 0, 0, 0);
      cyc(1, 8'h36, 16'h1abc, 1, 0, 0);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);
      // Flush racing an accept into a one-entry buffer
      cyc(1, 8'h37, 16'h6321, 0, 0, 0);
      cyc(1, 8'h38, 16'h1321, 1, 0, 0);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);
      // Asynchronous reset with one entry buffered and HALT pending
      cyc(1, 8'h40, 16'h1123, 0, 0, 0);
      cyc(1, 8'h41, 16'hF000, 0, 0, 0);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);
      @(negedge clk);
      bus.out_ready = 1'b0;
      #4;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", bus.out_valid, 1'b0);
      chk("arst_halted",    halted, 1'b0);
      chk("arst_in_ready",  bus.in_ready, 1'b0);
      chk("arst_out_pc",    bus.out_pc, 8'h0);
      exp_q.delete();
      m_halt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 8'h50, 16'h5a5b, 0, 0, 1);
      cyc(0, 8'h00, 16'h0000, 0, 0, 1);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         ix = $urandom_range(0, 7);
         if (ix == 6 && $urandom_range(0, 3) != 0)
            ix = 1;
         rnd_ins = {ops[ix], 12'($urandom)};
         cyc($urandom_range(0, 9) < 8, 8'($urandom), rnd_ins,
             $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) < 7);
      end

      repeat (4) cyc(0, 8'h00, 16'h0000, 0, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised instruction-decode stage with an elastic ID/EX boundary. It slices and decodes the fetched instruction, resolves jumps and halts in ID, and buffers decoded micro-ops in a 2-entry skid FIFO under a valid/ready handshake. The valid/ready handshake replaces the fixed stall/flush ID/EX register. It sits between the fetch stage (upstream handshake, jump redirect) and the execute stage (downstream handshake).

## Interface
- DATA_WIDTH, 16: instruction width.
- ADDR_WIDTH, 8: PC width.
- REG_WIDTH, 4: register specifier width.
- OP_WIDTH, 4: opcode width, taken from instr[DATA_WIDTH-1 -: OP_WIDTH].
- IMM_WIDTH, 8: immediate / jump-target width, taken from instr[IMM_WIDTH-1:0].
- CV_WIDTH, 9: control vector width, {Floating, Mov, MemToReg, MemWrite, RegDst, MemRead, Branch, ALUop, RegWrite}, MSB first.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_pc  in  ADDR_WIDTH  PC of the instruction.
- in_instr  in  DATA_WIDTH  instruction word.
- flush  in  1  discard buffered and incoming micro-ops.
- resume  in  1  leave HALT.
- jump  out  1  combinational; asserted when a J instruction is accepted.
- jump_addr  out  IMM_WIDTH  combinational; in_instr[IMM_WIDTH-1:0].
- rs_d, rt_d  out  REG_WIDTH  combinational; instr[11:8] and instr[7:4], for the hazard unit.
- reg_write_d, r_type_d  out  1  combinational decode of in_instr, for the hazard unit.
- out_valid  out  1  head micro-op valid.
- out_ready  in  1  execute consumes the head.
- out_pc  out  ADDR_WIDTH  head PC.
- out_rs, out_rt, out_rd  out  REG_WIDTH  head register specifiers.
- out_imm  out  IMM_WIDTH  head immediate.
- out_ctrl  out  CV_WIDTH  head control vector.
- halted  out  1  in HALT with the FIFO empty.

## Operation
- The opcode map is fixed:
  - 0x0 NOP: all control bits 0.
  - 0x1 ADD: RegWrite, RegDst, ALUop; R-type.
  - 0x5 LW: RegWrite, MemRead, MemToReg.
  - 0x6 SW: MemWrite.
  - 0x8 BEQ: Branch, ALUop.
  - 0x9 J: jump.
  - 0xF STOP: stop.
  - All other opcodes decode as NOP.
- Accept condition: in_valid & in_ready.
- in_ready = rst_n & (state==RUN) & (count<2). It does not depend on out_ready.
- Accepted J: jump=1. Nothing is pushed into the FIFO.
- Accepted STOP: pushed as a NOP micro-op; state moves to HALT on the next edge.
- Accepted any other opcode: push {pc, rs, rt, rd, imm, ctrl}.
- Pop condition: out_valid & out_ready. out_valid = (count!=0). Outputs always show the head entry.
- State machine:
  - RUN -> HALT on an accepted STOP.
  - HALT -> RUN on resume=1 at a clock edge.
  - In HALT, in_ready=0.
  - halted = (state==HALT) & (count==0).
- flush=1:
  - At the next edge, count becomes 0 and all entries are invalidated.
  - An instruction accepted in the same cycle is dropped. Its jump output still asserts combinationally; fetch ignores it under flush.
  - A STOP accepted in the same cycle is dropped and does not enter HALT.
  - flush does not change state.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes the head on the next edge.
  - count=2: no push is possible.
  - count=0: no pop is possible.
- flush and resume in the same cycle: both take effect.

## Timing
- Reset (rst_n low, asynchronous):
  - count=0, state=RUN.
  - All out_* and halted = 0.
  - in_ready=0 while rst_n is low.
- Latency: an instruction accepted at edge t with an empty FIFO gives out_valid=1 with its fields after edge t.
- Throughput: one micro-op per cycle when out_ready is held at 1.
- With out_ready=0, exactly 2 micro-ops are absorbed; in_ready falls the cycle after the second accept.
- jump, jump_addr, rs_d, rt_d, reg_write_d and r_type_d are combinational from in_instr and in_valid, with zero latency.
- A reset asserted mid-operation discards FIFO contents and HALT status immediately.

## Structure
- Package decode_pkg holds:
  - the opcode localparams (OP_NOP, OP_ADD, OP_LW, OP_SW, OP_BEQ, OP_J, OP_STOP);
  - the control-vector bit-index localparams;
  - the state encoding (RUN=0, HALT=1).
- Sub-module decode_ctrl: purely combinational opcode -> {ctrl, jump, stop, r_type}, taking its table from decode_pkg.
- The 2-entry FIFO and the state machine stay inline: pointers, count and a packed entry register.

## Test plan
- Reset, then stream ADD r3=r1+r2 (0x1123) at PC 0x10 with out_ready=1 -> after one edge: out_valid=1, out_pc=0x10, out_rs=1, out_rt=2, out_rd=3, out_ctrl=0x013.
- Push LW (0x5450) and SW (0x6450) with out_ready=0 -> in_ready=0 after the second accept; raise out_ready -> LW then SW pop in order with ctrl 0x049 and 0x020.
- J 0x9042 with in_valid=1 -> jump=1 and jump_addr=0x42 in the same cycle; FIFO count unchanged.
- STOP (0xF000) -> in_ready=0 from the next cycle; halted=1 once the STOP NOP drains; resume=1 -> in_ready=1 and halted=0.
- With 2 entries buffered, flush=1 together with an incoming ADD -> out_valid=0 next cycle and the ADD is never emitted.
- Drop rst_n mid-stream with 1 entry buffered and state HALT -> out_valid=0 and halted=0 immediately; after release, state is RUN and in_ready=1.
